ps2_cmd_sequencer: RTL and testbench
====================================

# ps2_cmd_sequencer

Host-side command scheduler for the PS/2 link. It shares the byte sender (send/busy handshake) between two requesters, sequences one- or two-byte device commands such as LED set (0xED, mask) and reset (0xFF), and waits for the device ACK after every byte. It retries on RESEND (0xFE) or timeout. Received bytes that are not part of a handshake are forwarded unchanged to the scan-code consumer. It sits between the requesters and the sender/reader pair.

## Interface
- ACK_TIMEOUT, 2000000: cycles allowed per phase (tx start, tx completion, ACK wait); 20 ms at 100 MHz.
- MAX_RETRY, 3: resend attempts per byte before error.
- ck  in  1  system clock, 100 MHz.
- reset  in  1  reset, asynchronous, active-high.
- req0 / req1  in  1  command request; held until done or err.
- len0 / len1  in  1  0 = one byte, 1 = two bytes.
- b0_0, b1_0 / b0_1, b1_1  in  8  first/second byte of requester 0/1.
- gnt  out  2  one-hot grant, held for the whole transaction.
- done  out  1  one-cycle pulse: transaction acknowledged.
- err  out  1  one-cycle pulse: retries exhausted.
- tx_send  out  1  one-cycle start pulse to the sender.
- tx_byte  out  8  byte to send, stable from SEND until the next LOAD.
- tx_busy  in  1  sender busy.
- rx_word_ready  in  1  reader byte strobe (1 cycle).
- rx_byte  in  8  reader byte.
- rx_valid  out  1  forwarded-byte strobe.
- rx_data  out  8  forwarded byte.

## Operation
- States: IDLE, SEND, WAIT_BUSY, WAIT_TX, WAIT_ACK, DONE, ERROR.
- IDLE: if any req is high, arbitrate round-robin (priority to the requester not granted last), register gnt, latch len/b0/b1, set byte index 0, set retry 0, load tx_byte = b0, go to SEND.
- SEND: tx_send = 1, go to WAIT_BUSY.
- WAIT_BUSY: on tx_busy = 1, go to WAIT_TX.
- WAIT_TX: on tx_busy = 0, go to WAIT_ACK.
- WAIT_ACK: on rx_word_ready with rx_byte:
  - 0xFA with index 0 and len = 1: index = 1, tx_byte = b1, clear retry, go to SEND.
  - 0xFA in any other case: go to DONE.
  - 0xFE: retry the current byte.
  - Other value: forward it and keep waiting.
- Timeout: in WAIT_BUSY, WAIT_TX or WAIT_ACK, the timer reaching ACK_TIMEOUT counts as a retry.
- Retry: if retry < MAX_RETRY, increment retry and return to SEND with the same tx_byte; otherwise go to ERROR.
- DONE: done = 1, go to IDLE. ERROR: err = 1, go to IDLE. gnt clears on entry to IDLE.
- Dropping req mid-transaction has no effect: the transaction completes. A new req is only sampled in IDLE.
- rx_valid = rx_word_ready, except in WAIT_ACK when rx_byte is 0xFA or 0xFE. rx_data = rx_byte, combinational.
- Timer: 22-bit, cleared on every state change, saturates at ACK_TIMEOUT.

## Timing
- Reset values: state IDLE; gnt, done, err, tx_send, rx_valid = 0; tx_byte = 0x00; last-grant pointer = 1, so req0 wins first.
- Reset mid-transaction: return to IDLE immediately; no done/err pulse.
- req high before edge N: gnt valid after edge N; tx_send high for the cycle after edge N+1.
- Both reqs high in the same cycle: the round-robin pointer decides. The pointer updates when gnt is registered.
- ACK arriving the same cycle the timer hits: the ACK wins.
- rx_word_ready during WAIT_BUSY or WAIT_TX: forwarded; it does not advance the FSM.
- tx_busy already high in SEND: WAIT_BUSY exits on the next cycle.
- Outputs decode from the state register, with no combinational path from req to tx_send.

## Structure
- Package ps2_link_pkg holds:
  - Constants: PS2_ACK = 8'hFA, PS2_RESEND = 8'hFE, PS2_CMD_LED = 8'hED, PS2_CMD_RESET = 8'hFF.
  - The state encoding.
- Sub-module ps2_timeout_timer(ck, reset, clr, hit), with parameter LIMIT.
- The arbiter and FSM stay in the top module.

## Test plan
- req0, len0 = 1, bytes 0xED/0x02; device ACKs each byte → two tx_send pulses carrying 0xED then 0x02, gnt = 01 throughout, one done pulse, no rx_valid for either 0xFA.
- req0 and req1 both high in the same cycle after reset → req0 served first. With req1 still high, req1 is served next (gnt = 10) and tx_byte = b0_1.
- Device answers 0xFE twice then 0xFA on single byte 0xFF → three tx_send pulses, all 0xFF; done asserted.
- No ACK ever (ACK_TIMEOUT = 100 in the bench) → 4 sends (1 + MAX_RETRY), err pulse, no done, gnt = 00 afterwards.
- Scan code 0x1C arrives during WAIT_ACK, then 0xFA → rx_valid pulse with rx_data = 0x1C; transaction completes.
- Reset asserted during WAIT_TX → all outputs 0 asynchronously. A fresh req1 afterwards is granted and handled normally.

Source files
------------

// File: rtl/ps2_link_pkg.sv
// ---------------------------------------------------------------------------
// ps2_link_pkg
// Shared definitions for the host side of the PS/2 link: protocol byte
// values, the command-sequencer state encoding and the timeout counter width.
// ---------------------------------------------------------------------------
package ps2_link_pkg;

    // Device-to-host handshake bytes
    localparam logic [7:0] PS2_ACK       = 8'hFA;
    localparam logic [7:0] PS2_RESEND    = 8'hFE;

    // Common host-to-device commands
    localparam logic [7:0] PS2_CMD_LED   = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET = 8'hFF;

    // 22 bits covers 20 ms at 100 MHz (2,000,000 cycles)
    localparam int TIMER_W = 22;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_TX,
        WAIT_ACK,
        DONE,
        ERROR
    } ps2_seq_state_e;

    // Bytes the sequencer consumes itself while waiting for a device answer
    function automatic logic is_handshake(input logic [7:0] b);
        return (b == PS2_ACK) || (b == PS2_RESEND);
    endfunction

endpackage

// File: rtl/ps2_timeout_timer.sv
// ---------------------------------------------------------------------------
// ps2_timeout_timer
// Free-running phase timer. Counts clock cycles since the last clr and
// saturates at LIMIT; hit stays high while the count sits at LIMIT.
//
// Ports
//   ck     in   system clock
//   reset  in   asynchronous active-high reset
//   clr    in   restart the count from zero on the next edge
//   hit    out  count has reached LIMIT
// ---------------------------------------------------------------------------
module ps2_timeout_timer
    import ps2_link_pkg::*;
#(
    parameter int LIMIT = 2000000
) (
    input  logic ck,
    input  logic reset,
    input  logic clr,
    output logic hit
);

    localparam logic [TIMER_W-1:0] LIM = TIMER_W'(LIMIT);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (count != LIM) begin
            count <= count + 1'b1;
        end
    end

    assign hit = (count == LIM);

endmodule

// File: rtl/ps2_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// ps2_cmd_sequencer
// Host-side command scheduler for the PS/2 link. Arbitrates the byte sender
// between two requesters (round-robin), sends one- or two-byte commands,
// waits for the device ACK after each byte and retries on RESEND or timeout.
// Received bytes that are not part of a handshake are forwarded.
//
// Ports
//   ck, reset              clock, asynchronous active-high reset
//   req0/req1              command requests, held until done or err
//   len0/len1              0 = one byte, 1 = two bytes
//   b0_0,b1_0 / b0_1,b1_1  first/second command byte per requester
//   gnt                    one-hot grant, held for the whole transaction
//   done / err             one-cycle completion / retries-exhausted pulses
//   tx_send, tx_byte       start pulse and byte to the sender
//   tx_busy                sender busy
//   rx_word_ready, rx_byte byte strobe and byte from the reader
//   rx_valid, rx_data      forwarded non-handshake bytes
// ---------------------------------------------------------------------------
module ps2_cmd_sequencer
    import ps2_link_pkg::*;
#(
    parameter int ACK_TIMEOUT = 2000000,
    parameter int MAX_RETRY   = 3
) (
    input  logic       ck,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       len0,
    input  logic       len1,
    input  logic [7:0] b0_0,
    input  logic [7:0] b1_0,
    input  logic [7:0] b0_1,
    input  logic [7:0] b1_1,
    output logic [1:0] gnt,
    output logic       done,
    output logic       err,
    output logic       tx_send,
    output logic [7:0] tx_byte,
    input  logic       tx_busy,
    input  logic       rx_word_ready,
    input  logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic [7:0] rx_data
);

    localparam int             RW   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0]  RMAX = RW'(MAX_RETRY);

    ps2_seq_state_e state, state_next;

    logic          last_gnt;     // index of the requester granted last
    logic          len_q;
    logic [7:0]    b1_q;
    logic          idx;          // byte index within the command
    logic [RW-1:0] retry;

    logic          sel;          // arbitration winner index
    logic          load_first;
    logic          load_second;
    logic          retry_inc;
    logic          fail;
    logic          timer_clr;
    logic          timer_hit;

    // Round-robin: on contention the requester not granted last wins
    assign sel = (req0 && req1) ? ~last_gnt : req1;

    // One timer serves every wait phase; it restarts on any state change
    assign timer_clr = (state_next != state);

    ps2_timeout_timer #(
        .LIMIT (ACK_TIMEOUT)
    ) u_timer (
        .ck    (ck),
        .reset (reset),
        .clr   (timer_clr),
        .hit   (timer_hit)
    );

    always_comb begin
        state_next  = state;
        load_first  = 1'b0;
        load_second = 1'b0;
        retry_inc   = 1'b0;
        fail        = 1'b0;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    load_first = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy)        state_next = WAIT_TX;
                else if (timer_hit) fail       = 1'b1;
            end
            WAIT_TX: begin
                if (!tx_busy)       state_next = WAIT_ACK;
                else if (timer_hit) fail       = 1'b1;
            end
            WAIT_ACK: begin
                // A device answer beats a timeout arriving in the same cycle
                if (rx_word_ready && (rx_byte == PS2_ACK)) begin
                    if (!idx && len_q) begin
                        load_second = 1'b1;
                        state_next  = SEND;
                    end else begin
                        state_next  = DONE;
                    end
                end else if (rx_word_ready && (rx_byte == PS2_RESEND)) begin
                    fail = 1'b1;
                end else if (timer_hit) begin
                    fail = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            ERROR:   state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (fail) begin
            if (retry < RMAX) begin
                retry_inc  = 1'b1;
                state_next = SEND;
            end else begin
                state_next = ERROR;
            end
        end
    end

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            gnt      <= 2'b00;
            last_gnt <= 1'b1;
            len_q    <= 1'b0;
            idx      <= 1'b0;
            retry    <= '0;
            tx_byte  <= 8'h00;
            tx_send  <= 1'b0;
        end else begin
            state   <= state_next;
            // Registered decode keeps req off any combinational path to tx_send
            tx_send <= (state == SEND);

            if (load_first) begin
                gnt      <= sel ? 2'b10 : 2'b01;
                last_gnt <= sel;
                len_q    <= sel ? len1 : len0;
                idx      <= 1'b0;
                retry    <= '0;
                tx_byte  <= sel ? b0_1 : b0_0;
            end

            if (load_second) begin
                idx     <= 1'b1;
                retry   <= '0;
                tx_byte <= b1_q;
            end

            if (retry_inc) begin
                retry <= retry + 1'b1;
            end

            // DONE and ERROR are the only ways back into IDLE
            if ((state == DONE) || (state == ERROR)) begin
                gnt <= 2'b00;
            end
        end
    end

    // Second command byte is pure data and only read after load_first
    always_ff @(posedge ck) begin
        if (load_first) begin
            b1_q <= sel ? b1_1 : b1_0;
        end
    end

    assign done     = (state == DONE);
    assign err      = (state == ERROR);
    assign rx_valid = rx_word_ready && !((state == WAIT_ACK) && is_handshake(rx_byte));
    assign rx_data  = rx_byte;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ps2_cmd_sequencer
// Self-checking bench: a sender/device model answers every transmitted byte
// from a response script; a transaction-level model derives the expected
// byte stream, grants, outcomes and forwarded bytes from the same script.
// ---------------------------------------------------------------------------
module tb_ps2_cmd_sequencer;

    localparam int TO = 100;
    localparam int MR = 3;

    typedef struct {
        bit         scan_en;   // device emits a scan code before its answer
        logic [7:0] scan;
        int         kind;      // 0 = ACK, 1 = RESEND, 2 = no answer
    } resp_t;

    logic       ck = 1'b0;
    logic       reset;
    logic       req0 = 1'b0, req1 = 1'b0, len0 = 1'b0, len1 = 1'b0;
    logic [7:0] b0_0 = 8'h00, b1_0 = 8'h00, b0_1 = 8'h00, b1_1 = 8'h00;
    logic [1:0] gnt;
    logic       done, err, tx_send;
    logic [7:0] tx_byte;
    logic       tx_busy = 1'b0;
    logic       rx_word_ready = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_valid;
    logic [7:0] rx_data;

    int n_checks = 0;
    int n_errors = 0;

    resp_t      script[16];
    resp_t      resp_q[$];
    bit         hold_busy = 1'b0;
    int         exp_last = 1;

    logic [7:0] obs_sent[$], exp_sent[$];
    logic [1:0] obs_gnt[$],  exp_gnt[$];
    int         obs_out[$],  exp_out[$];
    logic [7:0] obs_fwd[$],  exp_fwd[$];

    ps2_cmd_sequencer #(
        .ACK_TIMEOUT (TO),
        .MAX_RETRY   (MR)
    ) dut (
        .ck            (ck),
        .reset         (reset),
        .req0          (req0),
        .req1          (req1),
        .len0          (len0),
        .len1          (len1),
        .b0_0          (b0_0),
        .b1_0          (b1_0),
        .b0_1          (b0_1),
        .b1_1          (b1_1),
        .gnt           (gnt),
        .done          (done),
        .err           (err),
        .tx_send       (tx_send),
        .tx_byte       (tx_byte),
        .tx_busy       (tx_busy),
        .rx_word_ready (rx_word_ready),
        .rx_byte       (rx_byte),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data)
    );

    always #5 ck = ~ck;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] oh(input int r);
        return (r == 1) ? 2'b10 : 2'b01;
    endfunction

    // Sender + device model and output monitor
    initial begin
        int    dphase;
        int    cnt;
        resp_t cur;
        dphase = 0;
        cnt    = 0;
        cur.scan_en = 1'b0; cur.scan = 8'h00; cur.kind = 2;
        forever begin
            @(negedge ck);
            if (tx_send) begin
                obs_sent.push_back(tx_byte);
                obs_gnt.push_back(gnt);
            end
            if (done) obs_out.push_back(1);
            if (err)  obs_out.push_back(0);
            rx_word_ready = 1'b0;
            if (reset) begin
                dphase  = 0;
                tx_busy = 1'b0;
            end else begin
                case (dphase)
                    0: if (tx_send) begin
                        dphase = 1;
                        cnt    = $urandom_range(0, 2);
                    end
                    1: if (cnt == 0) begin
                        tx_busy = 1'b1;
                        cnt     = hold_busy ? 12 : $urandom_range(1, 4);
                        dphase  = 2;
                    end else cnt--;
                    2: if (cnt == 0) begin
                        tx_busy = 1'b0;
                        if (resp_q.size() > 0) cur = resp_q.pop_front();
                        else begin
                            cur.scan_en = 1'b0; cur.scan = 8'h00; cur.kind = 2;
                        end
                        cnt    = $urandom_range(1, 3);
                        dphase = 3;
                    end else cnt--;
                    3: if (cnt > 0) cnt--;
                    else if (cur.scan_en) begin
                        rx_word_ready = 1'b1;
                        rx_byte       = cur.scan;
                        cur.scan_en   = 1'b0;
                        cnt           = $urandom_range(1, 3);
                    end else begin
                        if (cur.kind != 2) begin
                            rx_word_ready = 1'b1;
                            rx_byte       = (cur.kind == 0) ? 8'hFA : 8'hFE;
                        end
                        dphase = 0;
                    end
                    default: dphase = 0;
                endcase
            end
            #1;
            if (rx_valid) obs_fwd.push_back(rx_data);
        end
    end

    // Transaction-level expectation for requester r, consuming script from k
    task automatic model_txn(input int r, inout int k);
        logic [7:0] bytes[2];
        int         nb;
        int         fails;
        bit         acked;
        bytes[0] = (r == 1) ? b0_1 : b0_0;
        bytes[1] = (r == 1) ? b1_1 : b1_0;
        nb       = (((r == 1) ? len1 : len0) == 1'b1) ? 2 : 1;
        for (int i = 0; i < nb; i++) begin
            fails = 0;
            acked = 1'b0;
            while (!acked) begin
                exp_sent.push_back(bytes[i]);
                exp_gnt.push_back(oh(r));
                if (script[k].scan_en) exp_fwd.push_back(script[k].scan);
                if (script[k].kind == 0) acked = 1'b1;
                else fails++;
                k++;
                if (fails > MR) begin
                    exp_out.push_back(0);
                    return;
                end
            end
        end
        exp_out.push_back(1);
    endtask

    task automatic gen_script(input bit all_ack);
        int r;
        for (int i = 0; i < 16; i++) begin
            r = $urandom_range(0, 19);
            script[i].scan_en = !all_ack && ($urandom_range(0, 9) < 3);
            script[i].scan    = 8'($urandom_range(0, 249));
            script[i].kind    = all_ack ? 0 : ((r < 12) ? 0 : (r < 17) ? 1 : 2);
        end
    endtask

    task automatic clear_obs();
        obs_sent.delete(); obs_gnt.delete(); obs_out.delete(); obs_fwd.delete();
    endtask

    task automatic run_case(input bit both, input int rid, input bit chk_lat);
        int order[$];
        int k;
        int w;
        int cnt;
        int n;
        k = 0;
        exp_sent.delete(); exp_gnt.delete(); exp_out.delete(); exp_fwd.delete();
        if (both) begin
            w     = (exp_last == 1) ? 0 : 1;
            order = {w, 1 - w};
        end else begin
            order = {rid};
        end
        for (int i = 0; i < order.size(); i++) begin
            model_txn(order[i], k);
            exp_last = order[i];
        end

        @(negedge ck); #2;
        clear_obs();
        resp_q.delete();
        for (int i = 0; i < 16; i++) resp_q.push_back(script[i]);
        if (both || rid == 0) req0 = 1'b1;
        if (both || rid == 1) req1 = 1'b1;

        if (chk_lat) begin
            @(negedge ck); #2;
            check_val("lat_gnt", 32'(gnt), 32'(oh(order[0])));
            check_val("lat_send_early", 32'(tx_send), 32'd0);
            @(negedge ck); #2;
            check_val("lat_send", 32'(tx_send), 32'd1);
        end

        for (int i = 0; i < order.size(); i++) begin
            cnt = 0;
            while (obs_out.size() < i + 1 && cnt < 3000) begin
                @(negedge ck); #2;
                cnt++;
            end
            if (cnt >= 3000) check_val("outcome_wait", 32'(obs_out.size()), 32'(i + 1));
            if (order[i] == 0) req0 = 1'b0;
            else               req1 = 1'b0;
        end
        repeat (6) begin
            @(negedge ck); #2;
        end

        check_val("n_sent", 32'(obs_sent.size()), 32'(exp_sent.size()));
        n = (obs_sent.size() < exp_sent.size()) ? obs_sent.size() : exp_sent.size();
        for (int i = 0; i < n; i++) begin
            check_val("sent_byte", 32'(obs_sent[i]), 32'(exp_sent[i]));
            check_val("sent_gnt",  32'(obs_gnt[i]),  32'(exp_gnt[i]));
        end
        check_val("n_outcome", 32'(obs_out.size()), 32'(exp_out.size()));
        n = (obs_out.size() < exp_out.size()) ? obs_out.size() : exp_out.size();
        for (int i = 0; i < n; i++) check_val("outcome", 32'(obs_out[i]), 32'(exp_out[i]));
        check_val("n_fwd", 32'(obs_fwd.size()), 32'(exp_fwd.size()));
        n = (obs_fwd.size() < exp_fwd.size()) ? obs_fwd.size() : exp_fwd.size();
        for (int i = 0; i < n; i++) check_val("fwd_byte", 32'(obs_fwd[i]), 32'(exp_fwd[i]));
        check_val("gnt_idle", 32'(gnt), 32'd0);
    endtask

    initial begin
        int cnt;
        reset = 1'b1;
        repeat (3) @(negedge ck);
        #2;
        check_val("rst_gnt",      32'(gnt),      32'd0);
        check_val("rst_done",     32'(done),     32'd0);
        check_val("rst_err",      32'(err),      32'd0);
        check_val("rst_tx_send",  32'(tx_send),  32'd0);
        check_val("rst_tx_byte",  32'(tx_byte),  32'd0);
        check_val("rst_rx_valid", 32'(rx_valid), 32'd0);
        reset    = 1'b0;
        exp_last = 1;

        // Contention straight after reset: req0 first, then req1
        len0 = 1'b0; len1 = 1'b0; b0_0 = 8'hF3; b0_1 = 8'hF4;
        gen_script(1'b1);
        run_case(1'b1, 0, 1'b1);

        // LED command, both bytes acknowledged
        len0 = 1'b1; b0_0 = 8'hED; b1_0 = 8'h02;
        gen_script(1'b1);
        run_case(1'b0, 0, 1'b0);

        // Two RESENDs then ACK on a reset command
        len1 = 1'b0; b0_1 = 8'hFF;
        gen_script(1'b1);
        script[0].kind = 1;
        script[1].kind = 1;
        run_case(1'b0, 1, 1'b0);

        // Device never answers: retries exhaust into err
        len0 = 1'b0; b0_0 = 8'hFF;
        gen_script(1'b1);
        for (int i = 0; i < 16; i++) script[i].kind = 2;
        run_case(1'b0, 0, 1'b0);

        // Scan code interleaved while waiting for the ACK
        len1 = 1'b0; b0_1 = 8'hF2;
        gen_script(1'b1);
        script[0].scan_en = 1'b1;
        script[0].scan    = 8'h1C;
        run_case(1'b0, 1, 1'b0);

        // Reset while the sender is still busy
        gen_script(1'b1);
        clear_obs();
        resp_q.delete();
        for (int i = 0; i < 16; i++) resp_q.push_back(script[i]);
        hold_busy = 1'b1;
        len0 = 1'b0; b0_0 = 8'hED;
        @(negedge ck); #2;
        req0 = 1'b1;
        cnt  = 0;
        while (!tx_busy && cnt < 50) begin
            @(negedge ck); #2;
            cnt++;
        end
        check_val("busy_seen", 32'(tx_busy), 32'd1);
        @(negedge ck); #2;
        check_val("pre_rst_gnt",  32'(gnt),     32'd1);
        check_val("pre_rst_byte", 32'(tx_byte), 32'hED);
        reset = 1'b1;
        #1;
        check_val("arst_gnt",      32'(gnt),      32'd0);
        check_val("arst_done",     32'(done),     32'd0);
        check_val("arst_err",      32'(err),      32'd0);
        check_val("arst_tx_send",  32'(tx_send),  32'd0);
        check_val("arst_tx_byte",  32'(tx_byte),  32'd0);
        check_val("arst_rx_valid", 32'(rx_valid), 32'd0);
        req0 = 1'b0;
        repeat (2) @(negedge ck);
        #2;
        reset     = 1'b0;
        hold_busy = 1'b0;
        clear_obs();
        resp_q.delete();
        repeat (5) begin
            @(negedge ck); #2;
        end
        check_val("post_rst_quiet", 32'(obs_out.size()), 32'd0);
        exp_last = 1;
        len1 = 1'b1; b0_1 = 8'hED; b1_1 = 8'h05;
        gen_script(1'b0);
        run_case(1'b0, 1, 1'b1);

        // Randomized traffic
        for (int t = 0; t < 30; t++) begin
            len0 = 1'($urandom_range(0, 1));
            len1 = 1'($urandom_range(0, 1));
            b0_0 = ($urandom_range(0, 3) == 0) ? 8'hED : 8'($urandom_range(0, 255));
            b1_0 = 8'($urandom_range(0, 255));
            b0_1 = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            b1_1 = 8'($urandom_range(0, 255));
            gen_script(1'b0);
            run_case($urandom_range(0, 3) == 0, $urandom_range(0, 1), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
